// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width, largest legal digit and a digit-validity helper.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_MAX     = 9;

    typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

    function automatic logic is_bcd(input bcd_digit_t d);
        return (d <= bcd_digit_t'(BCD_MAX));
    endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Bundles the load/count controls and the count/status outputs of one BCD countdown timer.
interface bcd_countdown_timer_if
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);
    logic                              load;
    logic [NUM_DIGITS*BCD_DIGIT_W-1:0] load_val;
    logic                              en;
    logic [NUM_DIGITS*BCD_DIGIT_W-1:0] q;
    logic                              zero;
    logic                              tc;
    logic                              load_err;

    modport master (
        output load, load_val, en,
        input  q, zero, tc, load_err
    );

    modport slave (
        input  load, load_val, en,
        output q, zero, tc, load_err
    );
endinterface

// File: rtl/bcd_down_decade.sv
// One BCD decade of a down counter: parallel load wins over decrement, 0 borrows to 9.
module bcd_down_decade
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  bcd_digit_t load_digit,
    input  logic       dec_in,
    output bcd_digit_t digit,
    output logic       borrow_out
);

    bcd_digit_t digit_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digit_reg <= '0;
        end else if (load) begin
            digit_reg <= load_digit;
        end else if (dec_in) begin
            digit_reg <= (digit_reg == '0) ? bcd_digit_t'(BCD_MAX) : digit_reg - 1'b1;
        end
    end

    assign digit      = digit_reg;
    assign borrow_out = (digit_reg == '0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-decade BCD countdown timer with validated load, optional auto-reload and a terminal-count pulse.
module bcd_countdown_timer
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter bit AUTO_RELOAD = 1'b0
)(
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              load,
    input  logic [NUM_DIGITS*BCD_DIGIT_W-1:0] load_val,
    input  logic                              en,
    output logic [NUM_DIGITS*BCD_DIGIT_W-1:0] Q,
    output logic                              zero,
    output logic                              tc,
    output logic                              load_err
);

    localparam int W = NUM_DIGITS * BCD_DIGIT_W;

    logic [NUM_DIGITS-1:0] digit_ok;
    logic [NUM_DIGITS-1:0] borrow;
    logic [NUM_DIGITS-1:0] lower_zero;
    logic [NUM_DIGITS-1:0] dec_in;
    logic                  load_ok;
    logic                  count_en;
    logic                  reload_now;
    logic                  dec_load;
    logic [W-1:0]          reload_reg;
    logic                  tc_reg;
    logic                  tc_next;
    logic                  load_err_reg;

    assign load_ok = &digit_ok;

    // Any load request, valid or not, suppresses counting; counting also stops at zero.
    assign count_en   = en & ~load & ~zero;
    assign reload_now = AUTO_RELOAD & en & ~load & zero;
    assign dec_load   = (load & load_ok) | reload_now;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_decade
            if (gi == 0) begin : g_first
                assign lower_zero[gi] = 1'b1;
            end else begin : g_rest
                assign lower_zero[gi] = lower_zero[gi-1] & borrow[gi-1];
            end

            assign digit_ok[gi] = is_bcd(load_val[gi*BCD_DIGIT_W +: BCD_DIGIT_W]);
            assign dec_in[gi]   = count_en & lower_zero[gi];

            bcd_down_decade u_decade (
                .clk        (clk),
                .reset_n    (reset_n),
                .load       (dec_load),
                .load_digit (load ? load_val[gi*BCD_DIGIT_W +: BCD_DIGIT_W]
                                  : reload_reg[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .dec_in     (dec_in[gi]),
                .digit      (Q[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .borrow_out (borrow[gi])
            );
        end
    endgenerate

    assign zero = lower_zero[NUM_DIGITS-1] & borrow[NUM_DIGITS-1];

    // Only a real decrement out of 1 marks terminal count; loads, reset and holding never do.
    assign tc_next = en & ~load & (Q == W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reload_reg   <= '0;
            tc_reg       <= 1'b0;
            load_err_reg <= 1'b0;
        end else begin
            if (load && load_ok) begin
                reload_reg <= load_val;
            end
            tc_reg       <= tc_next;
            load_err_reg <= load & ~load_ok;
        end
    end

    assign tc       = tc_reg;
    assign load_err = load_err_reg;

endmodule

// File: doc/bcd_countdown_timer.md
BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of BCD decades; legal range 1..8.
REQ-002 SHALL have parameter AUTO_RELOAD, default 0: 1 = reload the stored value after reaching zero; 0 = hold at zero.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port load  input  1  load request, sampled on the rising clk edge.
REQ-006 SHALL have port load_val  input  4*NUM_DIGITS  BCD value to load; digit 0 in bits [3:0].
REQ-007 SHALL have port en  input  1  count-down enable, one decrement per enabled cycle.
REQ-008 SHALL have port Q  output  4*NUM_DIGITS  current registered BCD count; digit 0 in bits [3:0].
REQ-009 SHALL have port zero  output  1  combinational; high while Q equals all-zero.
REQ-010 SHALL have port tc  output  1  registered terminal-count pulse.
REQ-011 SHALL have port load_err  output  1  registered pulse; load rejected for containing a non-BCD digit.

Function
REQ-012 Priority order SHALL be: reset_n, then load, then en.
REQ-013 Valid load (every load_val digit 0..9) SHALL set Q = load_val and reload register = load_val at the next edge, regardless of en.
REQ-014 Invalid load (any digit 10..15) SHALL leave Q and the reload register unchanged and assert load_err for exactly one cycle; en is ignored in that cycle.
REQ-015 en=1, load=0, Q!=0: Q SHALL decrement by one in BCD; latency one cycle.
REQ-016 Digit i SHALL decrement only when en=1 and digits 0..i-1 are all 0; when decremented, a digit at 0 wraps to 9 (borrow).
REQ-017 Example: Q=0x1000 (NUM_DIGITS=4), en -> Q=0x0999 in one cycle.
REQ-018 tc SHALL be high for exactly the one cycle in which Q first equals zero as the result of a decrement from value 1.
REQ-019 A load to zero, reset, or holding at zero SHALL NOT assert tc.
REQ-020 en=1 with Q=0, AUTO_RELOAD=0: Q SHALL hold 0; tc stays low.
REQ-021 en=1 with Q=0, AUTO_RELOAD=1: Q SHALL become the reload register value at the next edge; if the reload register is 0, Q stays 0.
REQ-022 en=0, load=0: Q SHALL hold.
REQ-023 Q SHALL never contain a non-BCD digit.

Reset
REQ-024 reset_n low SHALL immediately, without waiting for clk, force Q=0, reload register=0, tc=0, load_err=0; zero is then 1.
REQ-025 Reset asserted mid-count SHALL abandon the count; no tc or load_err SHALL follow reset release.
REQ-026 The first edge after reset_n rises SHALL obey REQ-012..REQ-022 normally.

Structure
REQ-027 Shared package bcd_pkg SHALL hold: BCD_DIGIT_W=4, BCD_MAX=9, the bcd_digit_t typedef, and an is_bcd digit-validity function.
REQ-028 Sub-module bcd_down_decade SHALL implement one digit: ports clk, reset_n, load, load_digit, dec_in, digit out, borrow_out (digit==0).
REQ-029 The top SHALL instantiate NUM_DIGITS decades via generate: dec_in[i] = en AND borrow_out of digits 0..i-1.
REQ-030 Load validation, reload register, tc, and load_err SHALL reside in the top.

Verification
REQ-031 Load 0x0100 then en one cycle -> Q=0x0099, tc=0, zero=0.
REQ-032 Q=0x0001 with en held, AUTO_RELOAD=0 -> Q=0x0000 with tc=1 for one cycle; subsequent cycles Q=0x0000, tc=0, zero=1.
REQ-033 AUTO_RELOAD=1: load 0x0003, en held -> Q sequence 3,2,1,0,3,2; tc high only in the cycles where Q=0.
REQ-034 Q=0x0042, load 0x00A5 -> load_err=1 for one cycle, Q stays 0x0042; load 0x0000 -> Q=0, tc=0.
REQ-035 load=1, load_val=0x0250, en=1 in the same cycle -> Q=0x0250, not decremented.
REQ-036 Q=0x0777, counting; reset_n pulsed low between edges -> Q=0 before the next edge; no tc after release.
